iq_integ4: RTL and testbench

IQ_INTEG4 -- requirements
Module: iq_integ4

---
 rtl/iq_integ4_pkg.sv | 32 +++
 rtl/iq_integ4_dinteg.sv | 55 +++++
 rtl/iq_integ4.sv | 84 ++++++++
 tb/tb_iq_integ4.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/iq_integ4_pkg.sv
// Shared constants, slot ordering and period clamping for the 4-channel
// IQ double integrator.
package iq_integ4_pkg;

  localparam int PERIOD_MIN = 8;
  localparam int PERIOD_MAX = 16;
  localparam int N_SLOTS    = 8;
  localparam int N_CH       = N_SLOTS / 2;

  // Output slot order within a frame: each channel contributes I then Q.
  typedef enum logic [2:0] {
    CH1_I = 3'd0,
    CH1_Q = 3'd1,
    CH2_I = 3'd2,
    CH2_Q = 3'd3,
    CH3_I = 3'd4,
    CH3_Q = 3'd5,
    CH4_I = 3'd6,
    CH4_Q = 3'd7
  } slot_e;

  // Limit a requested frame length to the range the serializer supports.
  function automatic logic [4:0] clamp_period(input logic [4:0] p);
    if (p < 5'(PERIOD_MIN))
      return 5'(PERIOD_MIN);
    else if (p > 5'(PERIOD_MAX))
      return 5'(PERIOD_MAX);
    else
      return p;
  endfunction

endpackage

// File: rtl/iq_integ4_dinteg.sv
// One IQ-interleaved double integrator pair. The I state advances only on
// iq=1 cycles, the Q state only on iq=0 cycles. All arithmetic wraps silently
// modulo 2^dwo so that downstream differencing recovers exact values.
module iq_dinteg
  #(
    parameter int dwi = 14,
    parameter int dwo = 22
  )
  (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  iq,
    input  logic signed [dwi-1:0] x,
    output logic signed [dwo-1:0] s2_i_next,
    output logic signed [dwo-1:0] s2_q_next
  );

  logic signed [dwo-1:0] xe;
  logic signed [dwo-1:0] s1_i_reg, s2_i_reg, s1_q_reg, s2_q_reg;
  logic signed [dwo-1:0] s1_i_next, s1_q_next;

  assign xe = {{(dwo-dwi){x[dwi-1]}}, x};

  // Next-state of both integrator chains; s2 accumulates the freshly updated s1.
  // s2_*_next is exported so the frame snapshot sees this cycle's update.
  always_comb begin
    s1_i_next = s1_i_reg;
    s2_i_next = s2_i_reg;
    s1_q_next = s1_q_reg;
    s2_q_next = s2_q_reg;
    if (iq) begin
      s1_i_next = s1_i_reg + xe;
      s2_i_next = s2_i_reg + s1_i_next;
    end else begin
      s1_q_next = s1_q_reg + xe;
      s2_q_next = s2_q_reg + s1_q_next;
    end
  end

  // Integrator state registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_i_reg <= '0;
      s2_i_reg <= '0;
      s1_q_reg <= '0;
      s2_q_reg <= '0;
    end else begin
      s1_i_reg <= s1_i_next;
      s2_i_reg <= s2_i_next;
      s1_q_reg <= s1_q_next;
      s2_q_reg <= s2_q_next;
    end
  end

endmodule

// File: rtl/iq_integ4.sv
// Four IQ double integrators feeding a frame snapshot and an 8-slot TDM
// serializer. Each frame is P clocks; at the last count the eight s2 values
// are captured and then shifted out one per clock, with sync on slot 0.
module iq_integ4
  import iq_integ4_pkg::*;
  #(
    parameter int dwi = 14,
    parameter int dwo = 22
  )
  (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  iq,
    input  logic signed [dwi-1:0] in1,
    input  logic signed [dwi-1:0] in2,
    input  logic signed [dwi-1:0] in3,
    input  logic signed [dwi-1:0] in4,
    input  logic [4:0]            period,
    output logic signed [dwo-1:0] out,
    output logic                  sync
  );

  logic signed [dwi-1:0] in_arr    [N_CH];
  logic signed [dwo-1:0] s2_next   [N_SLOTS];
  logic signed [dwo-1:0] shreg_reg [N_SLOTS];
  logic [4:0]            cnt_reg;
  logic [4:0]            p_reg;
  logic                  sync_reg;
  logic                  frame_last;

  assign in_arr[0] = in1;
  assign in_arr[1] = in2;
  assign in_arr[2] = in3;
  assign in_arr[3] = in4;

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      localparam int SLOT_I = int'(CH1_I) + 2 * gi;
      localparam int SLOT_Q = int'(CH1_Q) + 2 * gi;
      iq_dinteg #(.dwi(dwi), .dwo(dwo)) u_dinteg (
        .clk       (clk),
        .reset     (reset),
        .iq        (iq),
        .x         (in_arr[gi]),
        .s2_i_next (s2_next[SLOT_I]),
        .s2_q_next (s2_next[SLOT_Q])
      );
    end
  endgenerate

  assign frame_last = (cnt_reg == p_reg - 5'd1);

  // Frame counter, period latch, snapshot and serializer. The period is only
  // re-latched at the frame boundary so a frame is never shortened in flight.
  // After the snapshot the register shifts toward slot 0 for seven clocks and
  // then holds, leaving slot 7 on out for the rest of a long frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg  <= '0;
      p_reg    <= clamp_period(period);
      sync_reg <= 1'b0;
      for (int i = 0; i < N_SLOTS; i++)
        shreg_reg[i] <= '0;
    end else if (frame_last) begin
      cnt_reg  <= '0;
      p_reg    <= clamp_period(period);
      sync_reg <= 1'b1;
      for (int i = 0; i < N_SLOTS; i++)
        shreg_reg[i] <= s2_next[i];
    end else begin
      cnt_reg  <= cnt_reg + 5'd1;
      sync_reg <= 1'b0;
      if (cnt_reg < 5'(N_SLOTS - 1)) begin
        for (int i = 0; i < N_SLOTS - 1; i++)
          shreg_reg[i] <= shreg_reg[i+1];
      end
    end
  end

  assign out  = shreg_reg[0];
  assign sync = sync_reg;

endmodule

// File: tb/tb_iq_integ4.sv
// Self-checking bench for iq_integ4: directed frame/period/reset scenarios
// plus randomized traffic compared each cycle against a behavioural model.
`timescale 1ns/1ps
module tb_iq_integ4;

  localparam int     DWI = 14;
  localparam int     DWO = 22;
  localparam longint MOD = 64'sd1 <<< DWO;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic                  iq = 1'b1;
  logic signed [DWI-1:0] in1 = '0, in2 = '0, in3 = '0, in4 = '0;
  logic [4:0]            period = 5'd8;
  logic signed [DWO-1:0] out;
  logic                  sync;

  int total = 0;
  int bad   = 0;

  // Per-phase constants applied by tick(); tog selects automatic iq toggling.
  logic signed [DWI-1:0] ci [4];
  logic signed [DWI-1:0] cq [4];
  bit                    tog = 1'b0;

  always #5 clk = ~clk;

  iq_integ4 #(.dwi(DWI), .dwo(DWO)) dut (
    .clk    (clk),
    .reset  (reset),
    .iq     (iq),
    .in1    (in1),
    .in2    (in2),
    .in3    (in3),
    .in4    (in4),
    .period (period),
    .out    (out),
    .sync   (sync)
  );

  task automatic check(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic longint wrap(input longint v);
    longint r;
    r = v % MOD;
    if (r < 0) r += MOD;
    if (r >= MOD / 2) r -= MOD;
    return r;
  endfunction

  function automatic int clampp(input int p);
    return (p < 8) ? 8 : ((p > 16) ? 16 : p);
  endfunction

  // ---------------- behavioural reference model ----------------
  // Integrator sums are kept as plain integers reduced modulo 2^DWO; the
  // output is described as "snapshot slot min(cycles since snapshot, 7)".
  longint m_s1 [8];
  longint m_s2 [8];
  longint m_snap [8];
  int     m_cnt, m_p, m_since;
  bit     m_sync;
  bit     m_valid = 1'b0;

  always @(negedge clk) begin : model
    longint xs [4];
    int     sl;
    if (m_valid) begin
      check("cyc_out", out, m_snap[m_since]);
      check("cyc_sync", sync, m_sync);
    end
    if (reset) begin
      for (int k = 0; k < 8; k++) begin
        m_s1[k] = 0; m_s2[k] = 0; m_snap[k] = 0;
      end
      m_cnt = 0; m_p = clampp(int'(period)); m_since = 7; m_sync = 1'b0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      xs[0] = longint'(in1); xs[1] = longint'(in2);
      xs[2] = longint'(in3); xs[3] = longint'(in4);
      for (int k = 0; k < 4; k++) begin
        sl = 2 * k + (iq ? 0 : 1);
        m_s1[sl] = wrap(m_s1[sl] + xs[k]);
        m_s2[sl] = wrap(m_s2[sl] + m_s1[sl]);
      end
      if (m_cnt == m_p - 1) begin
        m_snap = m_s2;
        m_since = 0; m_sync = 1'b1; m_cnt = 0;
        m_p = clampp(int'(period));
      end else begin
        m_cnt++;
        if (m_since < 7) m_since++;
        m_sync = 1'b0;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    if (tog) iq = ~iq;
    in1 = iq ? ci[0] : cq[0];
    in2 = iq ? ci[1] : cq[1];
    in3 = iq ? ci[2] : cq[2];
    in4 = iq ? ci[3] : cq[3];
  endtask

  task automatic set_vals(input int a0, input int a1, input int a2, input int a3,
                          input int b0, input int b1, input int b2, input int b3);
    ci[0] = DWI'(a0); ci[1] = DWI'(a1); ci[2] = DWI'(a2); ci[3] = DWI'(a3);
    cq[0] = DWI'(b0); cq[1] = DWI'(b1); cq[2] = DWI'(b2); cq[3] = DWI'(b3);
  endtask

  // Hold reset for some cycles, confirm quiet outputs, then release.
  task automatic do_reset(input int p, input int cycles);
    reset = 1'b1;
    period = 5'(p);
    repeat (cycles) tick();
    check("rst_out", out, 0);
    check("rst_sync", sync, 0);
    reset = 1'b0;
  endtask

  // Count cycles until sync is seen, starting from a given cycle number.
  task automatic wait_sync(input int start, output int n);
    n = start;
    do begin
      tick();
      n++;
    end while (sync !== 1'b1 && n < start + 64);
    if (sync !== 1'b1) check("sync_timeout", sync, 1);
  endtask

  // Capture the eight slots starting at the current (sync) cycle.
  task automatic cap_here(output longint v [8]);
    v[0] = longint'(out);
    for (int j = 1; j < 8; j++) begin
      tick();
      v[j] = longint'(out);
    end
  endtask

  task automatic get_frame(output longint v [8]);
    int n;
    wait_sync(0, n);
    cap_here(v);
  endtask

  initial begin
    int     n;
    int     frames;
    longint f1 [8], f2 [8], f3 [8];
    longint d;

    set_vals(0, 0, 0, 0, 0, 0, 0, 0);

    // A: period 8, in1=100 with iq held high -> P updates per frame.
    tog = 1'b0; iq = 1'b1;
    set_vals(100, 0, 0, 0, 100, 0, 0, 0);
    do_reset(8, 3);
    wait_sync(1, n);
    check("a_first_sync", n, 9);
    cap_here(f1);
    get_frame(f2);
    get_frame(f3);
    check("a_first_frame", f1[0], 100 * 8 * 9 / 2);
    for (int j = 0; j < 8; j++) begin
      d = wrap(f3[j] - 2 * f2[j] + f1[j]);
      check($sformatf("a_d2_slot%0d", j), d, (j == 0) ? 64'sd6400 : 64'sd0);
    end

    // B: period 16, full-scale negative on ch3; state wraps, difference exact.
    set_vals(0, 0, -8192, 0, 0, 0, -8192, 0);
    do_reset(16, 2);
    wait_sync(1, n);
    check("b_first_sync", n, 17);
    cap_here(f1);
    get_frame(f2);
    get_frame(f3);
    check("b_d2_slot4", wrap(f3[4] - 2 * f2[4] + f1[4]), -64'sd2097152);
    check("b_d2_slot5", wrap(f3[5] - 2 * f2[5] + f1[5]), 64'sd0);

    // C: period changes take effect only on the following frame, clamped.
    tog = 1'b1;
    set_vals(7, 3, -2, 5, 1, -9, 4, 2);
    do_reset(8, 2);
    wait_sync(1, n);
    check("c_first_sync", n, 9);
    period = 5'd12;
    wait_sync(0, n); check("c_keep8", n, 8);
    wait_sync(0, n); check("c_new12", n, 12);
    period = 5'd3;
    wait_sync(0, n); check("c_keep12", n, 12);
    wait_sync(0, n); check("c_clamp_min", n, 8);
    period = 5'd31;
    wait_sync(0, n); check("c_keep8b", n, 8);
    wait_sync(0, n); check("c_clamp_max", n, 16);
    period = 5'd8;

    // D: distinct I/Q constants per channel, iq toggling -> 4 updates/frame.
    set_vals(11, -22, 33, -44, -5, 66, -77, 88);
    do_reset(8, 2);
    get_frame(f1);
    get_frame(f2);
    get_frame(f3);
    for (int j = 0; j < 8; j++) begin
      d = wrap(f3[j] - 2 * f2[j] + f1[j]);
      check($sformatf("d_order_slot%0d", j), d,
            16 * longint'((j % 2 == 0) ? ci[j/2] : cq[j/2]));
    end

    // E: one-cycle reset at frame count 5 aborts the frame.
    tog = 1'b0; iq = 1'b1;
    set_vals(0, 0, 0, 50, 0, 0, 0, 50);
    do_reset(8, 2);
    wait_sync(1, n);
    repeat (5) tick();
    reset = 1'b1;
    tick();
    check("e_rst_out", out, 0);
    check("e_rst_sync", sync, 0);
    reset = 1'b0;
    wait_sync(1, n);
    check("e_resync", n, 9);
    repeat (6) tick();
    check("e_restart_val", out, 50 * 8 * 9 / 2);

    // F: randomized back-to-back frames, checked every cycle by the model.
    tog = 1'b0;
    period = 5'd8;
    frames = 0;
    for (int c = 0; c < 50000 && frames < 3000; c++) begin
      tick();
      if (sync === 1'b1) frames++;
      if ($urandom_range(15) != 0) iq = ~iq;
      in1 = DWI'($urandom);
      in2 = DWI'($urandom);
      in3 = DWI'($urandom);
      in4 = DWI'($urandom);
      if ($urandom_range(49) == 0) period = 5'($urandom_range(31));
      reset = ($urandom_range(2999) == 0);
    end
    reset = 1'b0;
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
